image_resize_bicubic_hscan: RTL and testbench

Horizontal tap generator for the bicubic resizer: accepts one source line as a 24-bit RGB pixel stream and produces, per destination pixel, the four neighbouring source pixels and the four signed cubic-kernel weights. It sits directly upstream of the bicubic multiply/accumulate stage and drives its `valid_i`/`data0..3_i`/`weight0..3_i` inputs one-for-one. That downstream stage has no backpressure, so this block owns all line sequencing and input stalling.

---
 rtl/image_resize_bicubic_hscan.sv | 261 ++++++++++++++++++++++++++
 tb/tb_image_resize_bicubic_hscan.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_resize_bicubic_hscan.sv
// Horizontal bicubic tap generator: streams one source line and emits a 4-pixel window plus
// Keys (a=-0.5) weights per destination pixel. Define HSCAN_HALF_PIXEL_EN for centre-aligned mapping.
module image_resize_bicubic_hscan #(
    parameter int unsigned SRC_W = 640,
    parameter int unsigned DST_W = 1024,
    parameter int unsigned CW    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [23:0] step_i,
    input  logic        valid_i,
    input  logic [23:0] data_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [23:0] data0_o,
    output logic [23:0] data1_o,
    output logic [23:0] data2_o,
    output logic [23:0] data3_o,
    output logic [9:0]  weight0_o,
    output logic [9:0]  weight1_o,
    output logic [9:0]  weight2_o,
    output logic [9:0]  weight3_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned AW = CW + 16;
    localparam int unsigned PW = 24;
    localparam int unsigned WW = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_acc, w_acc_nxt;
    logic [23:0]   r_step, w_step_nxt;
    logic [CW-1:0] r_i, w_i_nxt;
    logic [CW-1:0] r_in_cnt, w_in_cnt_nxt;
    logic [CW-1:0] r_out_cnt, w_out_cnt_nxt;
    logic [PW-1:0] r_p0, r_p1, r_p2, r_p3;
    logic [PW-1:0] w_p0_nxt, w_p1_nxt, w_p2_nxt, w_p3_nxt;
    logic          r_valid, w_valid_nxt;
    logic [PW-1:0] r_d0, r_d1, r_d2, r_d3;
    logic [PW-1:0] w_d0_nxt, w_d1_nxt, w_d2_nxt, w_d3_nxt;
    logic [WW-1:0] r_w0, r_w1, r_w2, r_w3;
    logic [WW-1:0] w_w0_nxt, w_w1_nxt, w_w2_nxt, w_w3_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_done, w_done_nxt;

    logic [CW-1:0] w_n;
    logic [7:0]    w_t;
    logic          w_in_left;
    logic          w_out_left;
    logic          w_emit;
    logic          w_shift_req;
    logic          w_take;
    logic [AW-1:0] w_init;
    logic [WW-1:0] w_kw0, w_kw1, w_kw2, w_kw3;

    // Keys kernel, round-half-up of 256*w(t/256); numerators are scaled by 2*2^16 so one shift divides.
    function automatic logic [WW-1:0] kw(input logic [7:0] t, input logic [1:0] k);
        int x, x2, x3, num;
        x  = 32'(t);
        x2 = x * x;
        x3 = x2 * x;
        case (k)
            2'd0:    num = 512 * x2 - x3 - 65536 * x;
            2'd2:    num = 1024 * x2 - 3 * x3 + 65536 * x;
            default: num = x3 - 256 * x2;
        endcase
        return WW'((num + 65536) >>> 17);
    endfunction

    assign w_n         = r_acc[AW-1:16];
    assign w_t         = r_acc[15:8];
    assign w_in_left   = (r_in_cnt != CW'(SRC_W));
    assign w_out_left  = (r_out_cnt != CW'(DST_W));
    assign w_emit      = (r_state == S_RUN) && (w_n == r_i) && w_out_left;
    assign w_shift_req = (r_state == S_RUN) && (w_n > r_i);
    assign w_take      = ready_o && valid_i;

    // Ready decodes registered state only, so it never depends combinationally on valid_i.
    assign ready_o = (r_state == S_PRIME)
                   || (w_shift_req && w_in_left)
                   || ((r_state == S_DRAIN) && w_in_left);

    assign w_kw0 = kw(w_t, 2'd0);
    assign w_kw2 = kw(w_t, 2'd2);
    assign w_kw3 = kw(w_t, 2'd3);
    assign w_kw1 = WW'(WW'(256) - w_kw0 - w_kw2 - w_kw3);

    // Start coordinate of the first destination pixel.
    always_comb begin
`ifdef HSCAN_HALF_PIXEL_EN
        if (step_i[23:1] < 23'h008000) begin
            w_init = '0;
        end else begin
            w_init = AW'(step_i[23:1] - 23'h008000);
        end
`else
        w_init = '0;
`endif
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_step_nxt    = r_step;
        w_i_nxt       = r_i;
        w_in_cnt_nxt  = r_in_cnt;
        w_out_cnt_nxt = r_out_cnt;
        w_p0_nxt      = r_p0;
        w_p1_nxt      = r_p1;
        w_p2_nxt      = r_p2;
        w_p3_nxt      = r_p3;
        w_valid_nxt   = 1'b0;
        w_d0_nxt      = r_d0;
        w_d1_nxt      = r_d1;
        w_d2_nxt      = r_d2;
        w_d3_nxt      = r_d3;
        w_w0_nxt      = r_w0;
        w_w1_nxt      = r_w1;
        w_w2_nxt      = r_w2;
        w_w3_nxt      = r_w3;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // A start coinciding with the done pulse belongs to the finished line and is dropped.
                if (start_i && !r_done) begin
                    w_step_nxt    = step_i;
                    w_acc_nxt     = w_init;
                    w_i_nxt       = '0;
                    w_in_cnt_nxt  = '0;
                    w_out_cnt_nxt = '0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = S_PRIME;
                end
            end
            S_PRIME: begin
                if (w_take) begin
                    w_in_cnt_nxt = r_in_cnt + CW'(1);
                    if (r_in_cnt == '0) begin
                        w_p0_nxt = data_i;
                        w_p1_nxt = data_i;
                    end else if (r_in_cnt == CW'(1)) begin
                        w_p2_nxt = data_i;
                    end else begin
                        w_p3_nxt    = data_i;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_emit) begin
                    w_valid_nxt   = 1'b1;
                    w_d0_nxt      = r_p0;
                    w_d1_nxt      = r_p1;
                    w_d2_nxt      = r_p2;
                    w_d3_nxt      = r_p3;
                    w_w0_nxt      = w_kw0;
                    w_w1_nxt      = w_kw1;
                    w_w2_nxt      = w_kw2;
                    w_w3_nxt      = w_kw3;
                    w_acc_nxt     = r_acc + AW'(r_step);
                    w_out_cnt_nxt = r_out_cnt + CW'(1);
                    if (r_out_cnt + CW'(1) == CW'(DST_W)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (w_shift_req && (valid_i || !w_in_left)) begin
                    w_p0_nxt = r_p1;
                    w_p1_nxt = r_p2;
                    w_p2_nxt = r_p3;
                    w_i_nxt  = r_i + CW'(1);
                    if (w_in_left) begin
                        w_p3_nxt     = data_i;
                        w_in_cnt_nxt = r_in_cnt + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (w_take) begin
                    w_in_cnt_nxt = r_in_cnt + CW'(1);
                end
                if (!w_in_left) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_step    <= '0;
            r_i       <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_p0      <= '0;
            r_p1      <= '0;
            r_p2      <= '0;
            r_p3      <= '0;
            r_valid   <= 1'b0;
            r_d0      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_d3      <= '0;
            r_w0      <= '0;
            r_w1      <= '0;
            r_w2      <= '0;
            r_w3      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_step    <= w_step_nxt;
            r_i       <= w_i_nxt;
            r_in_cnt  <= w_in_cnt_nxt;
            r_out_cnt <= w_out_cnt_nxt;
            r_p0      <= w_p0_nxt;
            r_p1      <= w_p1_nxt;
            r_p2      <= w_p2_nxt;
            r_p3      <= w_p3_nxt;
            r_valid   <= w_valid_nxt;
            r_d0      <= w_d0_nxt;
            r_d1      <= w_d1_nxt;
            r_d2      <= w_d2_nxt;
            r_d3      <= w_d3_nxt;
            r_w0      <= w_w0_nxt;
            r_w1      <= w_w1_nxt;
            r_w2      <= w_w2_nxt;
            r_w3      <= w_w3_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign valid_o   = r_valid;
    assign data0_o   = r_d0;
    assign data1_o   = r_d1;
    assign data2_o   = r_d2;
    assign data3_o   = r_d3;
    assign weight0_o = r_w0;
    assign weight1_o = r_w1;
    assign weight2_o = r_w2;
    assign weight3_o = r_w3;
    assign busy_o    = r_busy;
    assign done_o    = r_done;

endmodule

// File: tb/tb_image_resize_bicubic_hscan.sv
// Bench for image_resize_bicubic_hscan: three instances (SRC_W 8/4/16, DST_W 8) checked against a
// coordinate-level model with real-valued kernel weights; honours HSCAN_HALF_PIXEL_EN when defined.
`timescale 1ns/1ps
module tb_image_resize_bicubic_hscan;

    localparam int NI = 3;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_s [NI];
    logic [23:0] step_s  [NI];
    logic        vin     [NI];
    logic [23:0] din     [NI];
    logic        rdy     [NI];
    logic        vout    [NI];
    logic [23:0] d0 [NI], d1 [NI], d2 [NI], d3 [NI];
    logic [9:0]  w0 [NI], w1 [NI], w2 [NI], w3 [NI];
    logic        busy    [NI];
    logic        done    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        image_resize_bicubic_hscan #(
            .SRC_W(g == 0 ? 8 : (g == 1 ? 4 : 16)),
            .DST_W(DW),
            .CW   (12)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .start_i  (start_s[g]),
            .step_i   (step_s[g]),
            .valid_i  (vin[g]),
            .data_i   (din[g]),
            .ready_o  (rdy[g]),
            .valid_o  (vout[g]),
            .data0_o  (d0[g]),
            .data1_o  (d1[g]),
            .data2_o  (d2[g]),
            .data3_o  (d3[g]),
            .weight0_o(w0[g]),
            .weight1_o(w1[g]),
            .weight2_o(w2[g]),
            .weight3_o(w3[g]),
            .busy_o   (busy[g]),
            .done_o   (done[g])
        );
    end

    int          sw [NI];
    logic [23:0] px [NI][16];
    logic [23:0] ed [NI][DW][4];
    int          ew [NI][DW][4];
    int          in_idx [NI], out_idx [NI], done_cnt [NI], last_v [NI], gap_mode [NI], line_start [NI];
    bit          active [NI], hs [NI], prev_stall [NI], lit [NI], probe [NI], expect_idle [NI];
    int          cyc;
    int          n_cmp, n_err;

    task automatic chk(input bit ok, input string nm, input string detail);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: %s", nm, detail);
        end
    endtask

    function automatic logic [23:0] rp(input int k);
        return {8'(k), 8'(k), 8'(k)};
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    // Kernel weight straight from the cubic polynomial; all intermediates are exact in double.
    function automatic int kw(input int t, input int k);
        real x, w;
        x = $itor(t) / 256.0;
        case (k)
            0:       w = (-x * x * x + 2.0 * x * x - x) / 2.0;
            2:       w = (-3.0 * x * x * x + 4.0 * x * x + x) / 2.0;
            default: w = (x * x * x - x * x) / 2.0;
        endcase
        return int'($floor(256.0 * w + 0.5));
    endfunction

    function automatic logic [23:0] tap(input int g, input int k);
        case (k)
            0:       return d0[g];
            1:       return d1[g];
            2:       return d2[g];
            default: return d3[g];
        endcase
    endfunction

    function automatic int wgt(input int g, input int k);
        case (k)
            0:       return int'($signed(w0[g]));
            1:       return int'($signed(w1[g]));
            2:       return int'($signed(w2[g]));
            default: return int'($signed(w3[g]));
        endcase
    endfunction

    function automatic bit wis(input int g, input int a, input int b, input int c, input int d);
        return wgt(g, 0) == a && wgt(g, 1) == b && wgt(g, 2) == c && wgt(g, 3) == d;
    endfunction

    // Expected outputs: destination j samples the clamped window around floor(acc_j).
    task automatic plan(input int g, input logic [23:0] s);
        longint acc;
        int n, t;
`ifdef HSCAN_HALF_PIXEL_EN
        acc = longint'(s) / 2 - 32768;
        if (acc < 0) acc = 0;
`else
        acc = 0;
`endif
        for (int j = 0; j < DW; j++) begin
            n = int'(acc / 65536);
            t = int'((acc / 256) % 256);
            for (int k = 0; k < 4; k++) ed[g][j][k] = px[g][clampi(n - 1 + k, sw[g] - 1)];
            ew[g][j][0] = kw(t, 0);
            ew[g][j][2] = kw(t, 2);
            ew[g][j][3] = kw(t, 3);
            ew[g][j][1] = 256 - ew[g][j][0] - ew[g][j][2] - ew[g][j][3];
            acc += longint'(s);
        end
    endtask

    task automatic check_lit(input int g, input int j);
        bit ok;
        ok = 1'b1;
        if (g == 0) begin
            ok = d1[g] == rp(j) && wis(g, 0, 256, 0, 0);
            if (j == 0) ok = ok && d0[g] == rp(0) && d2[g] == rp(1) && d3[g] == rp(2);
            if (j == 7) ok = ok && d0[g] == rp(6) && d2[g] == rp(7) && d3[g] == rp(7);
        end else if (g == 1) begin
            if (j % 2 == 1) ok = wis(g, -16, 144, 144, -16);
            else            ok = wis(g, 0, 256, 0, 0);
        end else begin
`ifdef HSCAN_HALF_PIXEL_EN
            ok = d1[g] == rp(2 * j) && wis(g, -16, 144, 144, -16);
`else
            ok = d1[g] == rp(2 * j) && wis(g, 0, 256, 0, 0);
`endif
        end
        chk(ok, "literal_taps", $sformatf("inst%0d out%0d got d0..3 %h %h %h %h w %0d %0d %0d %0d",
            g, j, d0[g], d1[g], d2[g], d3[g], wgt(g, 0), wgt(g, 1), wgt(g, 2), wgt(g, 3)));
    endtask

    task automatic check_outputs(input int g);
        bit ok;
        int j;
        if (expect_idle[g]) begin
            chk(!busy[g] && !vout[g], "start_at_done", $sformatf("inst%0d busy=%0b valid=%0b required 0 0", g, busy[g], vout[g]));
            expect_idle[g] = 1'b0;
        end
        if (prev_stall[g]) begin
            chk(rdy[g] && !vout[g], "stall_hold", $sformatf("inst%0d ready=%0b valid=%0b required 1 0", g, rdy[g], vout[g]));
        end
        if (!busy[g]) begin
            chk(!rdy[g], "idle_ready", $sformatf("inst%0d ready=%0b required 0", g, rdy[g]));
        end
        if (vout[g]) begin
            j = out_idx[g];
            if (!active[g] || j >= DW) begin
                chk(1'b0, "extra_valid", $sformatf("inst%0d valid_o with %0d outputs already seen, required none", g, j));
            end else begin
                ok = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    if (tap(g, k) != ed[g][j][k] || wgt(g, k) != ew[g][j][k]) ok = 1'b0;
                end
                chk(ok, "taps", $sformatf("inst%0d out%0d got %h %h %h %h / %0d %0d %0d %0d required %h %h %h %h / %0d %0d %0d %0d",
                    g, j, d0[g], d1[g], d2[g], d3[g], wgt(g, 0), wgt(g, 1), wgt(g, 2), wgt(g, 3),
                    ed[g][j][0], ed[g][j][1], ed[g][j][2], ed[g][j][3], ew[g][j][0], ew[g][j][1], ew[g][j][2], ew[g][j][3]));
                if (lit[g]) check_lit(g, j);
                out_idx[g]++;
                last_v[g] = cyc;
            end
        end
        if (done[g]) begin
            done_cnt[g]++;
            chk(out_idx[g] == DW && in_idx[g] == sw[g] && last_v[g] < cyc && !busy[g], "done_state",
                $sformatf("inst%0d outputs=%0d inputs=%0d last_valid=%0d done=%0d busy=%0b required %0d %0d earlier busy 0",
                g, out_idx[g], in_idx[g], last_v[g], cyc, busy[g], DW, sw[g]));
            active[g] = 1'b0;
            if (probe[g]) begin
                start_s[g]     = 1'b1;
                step_s[g]      = 24'h010000;
                expect_idle[g] = 1'b1;
                probe[g]       = 1'b0;
            end
        end
    endtask

    task automatic drive(input int g);
        bit v;
        v = 1'b0;
        if (active[g] && in_idx[g] < sw[g]) begin
            case (gap_mode[g])
                1:       v = ($urandom_range(0, 3) != 0);
                2:       v = !((cyc - line_start[g]) >= 10 && (cyc - line_start[g]) < 15);
                default: v = 1'b1;
            endcase
        end
        vin[g] = v;
        if (v) din[g] = px[g][in_idx[g]];
        else   din[g] = 24'($urandom);
    endtask

    task automatic tick();
        for (int g = 0; g < NI; g++) begin
            hs[g]         = vin[g] && rdy[g] && !reset;
            prev_stall[g] = busy[g] && rdy[g] && !vin[g] && !reset;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int g = 0; g < NI; g++) begin
            start_s[g] = 1'b0;
            if (hs[g]) in_idx[g]++;
            check_outputs(g);
            drive(g);
        end
    endtask

    task automatic start_lines(input logic [23:0] s0, input logic [23:0] s1, input logic [23:0] s2,
                               input int mode, input bit litc);
        logic [23:0] st [NI];
        st[0] = s0;
        st[1] = s1;
        st[2] = s2;
        for (int g = 0; g < NI; g++) begin
            plan(g, st[g]);
            in_idx[g]     = 0;
            out_idx[g]    = 0;
            done_cnt[g]   = 0;
            last_v[g]     = -1;
            gap_mode[g]   = mode;
            lit[g]        = litc;
            active[g]     = 1'b1;
            line_start[g] = cyc;
            start_s[g]    = 1'b1;
            step_s[g]     = st[g];
        end
        tick();
    endtask

    task automatic wait_lines(input int bound);
        int  t0;
        bit  all;
        t0  = cyc;
        all = 1'b0;
        while (!all && (cyc - t0) < bound) begin
            tick();
            all = 1'b1;
            for (int g = 0; g < NI; g++) if (done_cnt[g] == 0) all = 1'b0;
        end
        for (int g = 0; g < NI; g++) begin
            chk(done_cnt[g] != 0, "line_timeout", $sformatf("inst%0d no done_o within %0d cycles, outputs=%0d inputs=%0d",
                g, bound, out_idx[g], in_idx[g]));
            active[g] = 1'b0;
        end
        repeat (3) tick();
        for (int g = 0; g < NI; g++) begin
            chk(done_cnt[g] == 1, "done_once", $sformatf("inst%0d done pulses=%0d required 1", g, done_cnt[g]));
        end
    endtask

    task automatic check_reset_state(input string nm);
        bit ok;
        for (int g = 0; g < NI; g++) begin
            ok = !vout[g] && !rdy[g] && !busy[g] && !done[g] && d0[g] == 0 && d1[g] == 0 && d2[g] == 0 && d3[g] == 0
                 && w0[g] == 0 && w1[g] == 0 && w2[g] == 0 && w3[g] == 0;
            chk(ok, nm, $sformatf("inst%0d valid=%0b ready=%0b busy=%0b done=%0b data %h %h %h %h weights %h %h %h %h, required all 0",
                g, vout[g], rdy[g], busy[g], done[g], d0[g], d1[g], d2[g], d3[g], w0[g], w1[g], w2[g], w3[g]));
        end
    endtask

    task automatic ramp_pixels();
        for (int g = 0; g < NI; g++) for (int k = 0; k < 16; k++) px[g][k] = rp(k);
    endtask

    initial begin
        int t0;
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        sw    = '{8, 4, 16};
        reset = 1'b1;
        for (int g = 0; g < NI; g++) begin
            start_s[g] = 1'b0; step_s[g] = '0; vin[g] = 1'b0; din[g] = '0;
            in_idx[g] = 0; out_idx[g] = 0; done_cnt[g] = 0; last_v[g] = -1; gap_mode[g] = 0; line_start[g] = 0;
            active[g] = 1'b0; hs[g] = 1'b0; prev_stall[g] = 1'b0; lit[g] = 1'b0; probe[g] = 1'b0; expect_idle[g] = 1'b0;
        end
        repeat (3) tick();
        check_reset_state("reset_state");
        reset = 1'b0;
        tick();

        // Test-plan ratios on ramps; start probes at the done cycle and while busy.
        ramp_pixels();
        start_lines(24'h010000, 24'h008000, 24'h020000, 0, 1'b1);
        probe[0] = 1'b1;
        repeat (6) tick();
        start_s[2] = 1'b1;
        step_s[2]  = 24'h008000;
        tick();
        wait_lines(400);

        // Same ratios with a 5-cycle valid_i gap mid-line.
        start_lines(24'h010000, 24'h008000, 24'h020000, 2, 1'b1);
        wait_lines(400);

        // Abort mid-line while instance 0 works on output 3, then rerun cleanly.
        start_lines(24'h010000, 24'h008000, 24'h020000, 0, 1'b1);
        t0 = cyc;
        while (out_idx[0] < 3 && (cyc - t0) < 200) tick();
        chk(out_idx[0] == 3, "reset_point", $sformatf("inst0 outputs=%0d required 3", out_idx[0]));
        reset = 1'b1;
        tick();
        check_reset_state("midline_reset");
        reset = 1'b0;
        for (int g = 0; g < NI; g++) active[g] = 1'b0;
        tick();
        start_lines(24'h010000, 24'h008000, 24'h020000, 0, 1'b1);
        wait_lines(400);

        // Random pixels, random steps, random valid_i gaps.
        for (int r = 0; r < 8; r++) begin
            for (int g = 0; g < NI; g++) for (int k = 0; k < 16; k++) px[g][k] = 24'($urandom);
            start_lines(24'($urandom_range(32'h004000, 32'h030000)), 24'($urandom_range(32'h004000, 32'h030000)),
                        24'($urandom_range(32'h004000, 32'h030000)), 1, 1'b0);
            wait_lines(1000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
